// File: rtl/writeback_pkg.sv
// Shared types and constants for the writeback stage and its machine-mode trap unit.
package writeback_pkg;

  localparam int WB_XLEN       = 32;
  localparam int WB_REG_ADDR_W = 5;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  localparam logic [1:0] CSR_OP_NONE  = 2'd0;
  localparam logic [1:0] CSR_OP_WRITE = 2'd1;
  localparam logic [1:0] CSR_OP_SET   = 2'd2;
  localparam logic [1:0] CSR_OP_CLEAR = 2'd3;

  localparam logic [4:0] CAUSE_ILLEGAL = 5'd2;
  localparam logic [4:0] CAUSE_EBREAK  = 5'd3;
  localparam logic [4:0] CAUSE_ECALL   = 5'd11;
  localparam logic [4:0] CAUSE_IRQ_EXT = 5'd11;
  localparam logic [4:0] CAUSE_IRQ_TMR = 5'd7;

  typedef struct packed {
    logic [WB_REG_ADDR_W-1:0] rd_addr;
    logic                     rd_write;
    logic [1:0]               csr_op;
    logic [11:0]              csr_addr;
    logic                     is_ecall;
    logic                     is_ebreak;
    logic                     is_illegal;
    logic                     is_mret;
  } wb_instr_t;

  typedef struct packed {
    logic                     valid;
    logic [WB_REG_ADDR_W-1:0] rd_addr;
    logic [WB_XLEN-1:0]       data;
  } fwd_t;

  typedef enum logic {RUN = 1'b0, TRAP = 1'b1} wb_state_e;

  // Interrupt line index -> mcause code; also the bit position in the mie/mip views.
  function automatic logic [4:0] irq_cause_of(input int idx);
    logic [4:0] c;
    case (idx)
      0:       c = CAUSE_IRQ_EXT;
      1:       c = CAUSE_IRQ_TMR;
      default: c = 5'(16 + idx - 2);
    endcase
    return c;
  endfunction

endpackage

// File: rtl/writeback_stage_trap_if.sv
// Memory-stage to writeback bus: retire inputs plus redirect and forwarding outputs.
interface writeback_stage_trap_if #(
  parameter int XLEN = writeback_pkg::WB_XLEN
);
  import writeback_pkg::*;

  logic            valid_in;
  logic            stall_out;
  wb_instr_t       instruction_in;
  logic [XLEN-1:0] rd_data_in;
  logic [XLEN-1:0] source_data_in;
  logic [XLEN-1:0] program_counter_in;
  logic [XLEN-1:0] next_program_counter_in;
  logic            jump_valid_out;
  logic [XLEN-1:0] jump_address_out;
  logic            flush_out;
  fwd_t            forwarding_out;

  modport master (
    output valid_in, instruction_in, rd_data_in, source_data_in,
           program_counter_in, next_program_counter_in,
    input  stall_out, jump_valid_out, jump_address_out, flush_out, forwarding_out
  );

  modport slave (
    input  valid_in, instruction_in, rd_data_in, source_data_in,
           program_counter_in, next_program_counter_in,
    output stall_out, jump_valid_out, jump_address_out, flush_out, forwarding_out
  );

endinterface

// File: rtl/trap_csr_file.sv
// Machine-mode CSR storage, read/modify logic and the interrupt priority encoder.
module trap_csr_file
  import writeback_pkg::*;
#(
  parameter int              XLEN        = WB_XLEN,
  parameter int              NUM_IRQ     = 2,
  parameter logic [XLEN-1:0] RESET_MTVEC = 32'h0000_0100
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic [1:0]         csr_op,
  input  logic [11:0]        csr_addr,
  input  logic [XLEN-1:0]    csr_operand,
  input  logic               csr_we,
  input  logic               trap_take,
  input  logic [XLEN-1:0]    trap_cause,
  input  logic [XLEN-1:0]    trap_pc,
  input  logic               mret_take,
  output logic [XLEN-1:0]    csr_rdata,
  output logic               csr_illegal,
  output logic               irq_pending,
  output logic [4:0]         irq_cause,
  output logic [XLEN-1:0]    mtvec,
  output logic [XLEN-1:0]    mepc
);

  logic               mie_bit_r;
  logic               mpie_bit_r;
  logic [NUM_IRQ-1:0] irq_en_r;
  logic [XLEN-1:0]    mtvec_r;
  logic [XLEN-1:0]    mepc_r;
  logic [XLEN-1:0]    mcause_r;
  logic [XLEN-1:0]    mie_view_s;
  logic [XLEN-1:0]    mip_view_s;
  logic [XLEN-1:0]    new_val_s;
  logic               addr_known_s;
  logic [NUM_IRQ-1:0] masked_s;
  logic [NUM_IRQ-1:0] lowest_s;

  // Spread per-line enables and requests onto their cause bit positions.
  always_comb begin
    mie_view_s = '0;
    mip_view_s = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      mie_view_s[irq_cause_of(i)] = irq_en_r[i];
      mip_view_s[irq_cause_of(i)] = irq[i];
    end
  end

  // CSR read mux; an address outside the implemented set is flagged.
  always_comb begin
    csr_rdata    = '0;
    addr_known_s = 1'b1;
    case (csr_addr)
      CSR_MSTATUS: begin
        csr_rdata[3] = mie_bit_r;
        csr_rdata[7] = mpie_bit_r;
      end
      CSR_MIE:    csr_rdata = mie_view_s;
      CSR_MTVEC:  csr_rdata = mtvec_r;
      CSR_MEPC:   csr_rdata = mepc_r;
      CSR_MCAUSE: csr_rdata = mcause_r;
      CSR_MIP:    csr_rdata = mip_view_s;
      default:    addr_known_s = 1'b0;
    endcase
  end

  assign csr_illegal = (csr_op != CSR_OP_NONE) && !addr_known_s;

  // Read-modify-write value for write/set/clear.
  always_comb begin
    case (csr_op)
      CSR_OP_WRITE: new_val_s = csr_operand;
      CSR_OP_SET:   new_val_s = csr_rdata | csr_operand;
      CSR_OP_CLEAR: new_val_s = csr_rdata & ~csr_operand;
      default:      new_val_s = csr_rdata;
    endcase
  end

  // Lowest enabled request index wins; isolate it as a one-hot.
  assign masked_s    = irq & irq_en_r;
  assign lowest_s    = masked_s & (~masked_s + NUM_IRQ'(1));
  assign irq_pending = mie_bit_r && (|masked_s);

  // Encode the winning line into its cause code.
  always_comb begin
    irq_cause = 5'd0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      irq_cause = irq_cause | ({5{lowest_s[i]}} & irq_cause_of(i));
    end
  end

  // CSR state update: trap entry, then mret, then an explicit CSR instruction.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mie_bit_r  <= 1'b0;
      mpie_bit_r <= 1'b0;
      irq_en_r   <= '0;
      mtvec_r    <= RESET_MTVEC;
      mepc_r     <= '0;
      mcause_r   <= '0;
    end else if (trap_take) begin
      mpie_bit_r <= mie_bit_r;
      mie_bit_r  <= 1'b0;
      mepc_r     <= {trap_pc[XLEN-1:2], 2'b00};
      mcause_r   <= trap_cause;
    end else if (mret_take) begin
      mie_bit_r  <= mpie_bit_r;
      mpie_bit_r <= 1'b1;
    end else if (csr_we) begin
      case (csr_addr)
        CSR_MSTATUS: begin
          mie_bit_r  <= new_val_s[3];
          mpie_bit_r <= new_val_s[7];
        end
        CSR_MIE: begin
          for (int i = 0; i < NUM_IRQ; i++) begin
            irq_en_r[i] <= new_val_s[irq_cause_of(i)];
          end
        end
        CSR_MTVEC:  mtvec_r  <= new_val_s;
        CSR_MEPC:   mepc_r   <= {new_val_s[XLEN-1:2], 2'b00};
        CSR_MCAUSE: mcause_r <= new_val_s;
        default: begin
          mcause_r <= mcause_r;
        end
      endcase
    end else begin
      mcause_r <= mcause_r;
    end
  end

  assign mtvec = mtvec_r;
  assign mepc  = mepc_r;

endmodule

// File: rtl/writeback_stage_trap.sv
// Pipeline-tail writeback stage: retire/forward, trap decision FSM and fetch redirect.
module writeback_stage_trap
  import writeback_pkg::*;
#(
  parameter int              XLEN        = WB_XLEN,
  parameter int              REG_ADDR_W  = WB_REG_ADDR_W,
  parameter int              NUM_IRQ     = 2,
  parameter logic [XLEN-1:0] RESET_MTVEC = 32'h0000_0100
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_IRQ-1:0]    irq_in,
  writeback_stage_trap_if.slave bus
);

  wb_state_e             state_r;
  wb_state_e             state_n;
  wb_instr_t             instr_s;
  logic [REG_ADDR_W-1:0] rd_addr_s;
  logic                  trap_take_s;
  logic [XLEN-1:0]       trap_cause_s;
  logic                  mret_take_s;
  logic                  retire_s;
  logic                  csr_we_s;
  logic                  exc_s;
  logic [4:0]            exc_cause_s;
  logic [XLEN-1:0]       csr_rdata_s;
  logic                  csr_illegal_s;
  logic                  irq_pending_s;
  logic [4:0]            irq_cause_s;
  logic [XLEN-1:0]       mtvec_s;
  logic [XLEN-1:0]       mepc_s;
  logic                  fwd_valid_s;
  fwd_t                  fwd_r;
  logic                  jump_valid_r;
  logic [XLEN-1:0]       jump_address_r;
  logic                  flush_r;
  logic                  stall_r;
  logic                  unused_next_pc_s;

  assign instr_s          = bus.instruction_in;
  assign rd_addr_s        = instr_s.rd_addr;
  assign unused_next_pc_s = ^bus.next_program_counter_in;

  trap_csr_file #(
    .XLEN        (XLEN),
    .NUM_IRQ     (NUM_IRQ),
    .RESET_MTVEC (RESET_MTVEC)
  ) u_csr (
    .clk         (clk),
    .rst         (rst),
    .irq         (irq_in),
    .csr_op      (instr_s.csr_op),
    .csr_addr    (instr_s.csr_addr),
    .csr_operand (bus.source_data_in),
    .csr_we      (csr_we_s),
    .trap_take   (trap_take_s),
    .trap_cause  (trap_cause_s),
    .trap_pc     (bus.program_counter_in),
    .mret_take   (mret_take_s),
    .csr_rdata   (csr_rdata_s),
    .csr_illegal (csr_illegal_s),
    .irq_pending (irq_pending_s),
    .irq_cause   (irq_cause_s),
    .mtvec       (mtvec_s),
    .mepc        (mepc_s)
  );

  // Synchronous exception priority: illegal (incl. unknown CSR) > ebreak > ecall.
  always_comb begin
    exc_s       = 1'b1;
    exc_cause_s = CAUSE_ILLEGAL;
    if (instr_s.is_illegal || csr_illegal_s) begin
      exc_cause_s = CAUSE_ILLEGAL;
    end else if (instr_s.is_ebreak) begin
      exc_cause_s = CAUSE_EBREAK;
    end else if (instr_s.is_ecall) begin
      exc_cause_s = CAUSE_ECALL;
    end else begin
      exc_s = 1'b0;
    end
  end

  // Next-state and retire decision; interrupts are only sampled with a valid instruction.
  always_comb begin
    state_n      = state_r;
    trap_take_s  = 1'b0;
    trap_cause_s = '0;
    mret_take_s  = 1'b0;
    retire_s     = 1'b0;
    csr_we_s     = 1'b0;
    case (state_r)
      RUN: begin
        if (!bus.valid_in) begin
          state_n = RUN;
        end else if (irq_pending_s) begin
          trap_take_s  = 1'b1;
          trap_cause_s = {1'b1, {(XLEN-6){1'b0}}, irq_cause_s};
          state_n      = TRAP;
        end else if (exc_s) begin
          trap_take_s  = 1'b1;
          trap_cause_s = {1'b0, {(XLEN-6){1'b0}}, exc_cause_s};
          state_n      = TRAP;
        end else if (instr_s.is_mret) begin
          mret_take_s = 1'b1;
        end else begin
          retire_s = 1'b1;
          csr_we_s = (instr_s.csr_op != CSR_OP_NONE);
        end
      end
      TRAP:    state_n = RUN;
      default: state_n = RUN;
    endcase
  end

  assign fwd_valid_s = retire_s && instr_s.rd_write && (rd_addr_s != '0);

  // State and registered outputs; a trap's redirect is presented during the TRAP cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r        <= RUN;
      fwd_r          <= '0;
      jump_valid_r   <= 1'b0;
      jump_address_r <= '0;
      flush_r        <= 1'b0;
      stall_r        <= 1'b0;
    end else begin
      state_r       <= state_n;
      fwd_r.valid   <= fwd_valid_s;
      fwd_r.rd_addr <= fwd_valid_s ? rd_addr_s : '0;
      if (!fwd_valid_s) begin
        fwd_r.data <= '0;
      end else if (instr_s.csr_op != CSR_OP_NONE) begin
        fwd_r.data <= csr_rdata_s;
      end else begin
        fwd_r.data <= bus.rd_data_in;
      end
      jump_valid_r <= trap_take_s || mret_take_s;
      flush_r      <= trap_take_s || mret_take_s;
      stall_r      <= trap_take_s;
      if (trap_take_s) begin
        jump_address_r <= {mtvec_s[XLEN-1:2], 2'b00};
      end else if (mret_take_s) begin
        jump_address_r <= mepc_s;
      end else begin
        jump_address_r <= '0;
      end
    end
  end

  assign bus.forwarding_out   = fwd_r;
  assign bus.jump_valid_out   = jump_valid_r;
  assign bus.jump_address_out = jump_address_r;
  assign bus.flush_out        = flush_r;
  assign bus.stall_out        = stall_r;

endmodule

// File: doc/writeback_stage_trap.md
Name: writeback_stage_trap

Overview:
Parametrised successor to the single-configuration writeback stage. Retires one instruction per cycle from the memory stage, drives the register-file forwarding/write bus, and owns a minimal machine-mode trap unit. The trap unit provides mstatus.MIE/MPIE, mie, mip, mtvec, mepc and mcause, NUM_IRQ prioritised interrupt lines, synchronous exceptions and MRET. It sits at the pipeline tail and redirects fetch through a jump/flush interface.

Parameters:
XLEN, 32, data/PC width
REG_ADDR_W, 5, register index width
NUM_IRQ, 2, interrupt lines (2..16); idx0=external (cause 11), idx1=timer (cause 7), idx i>=2 -> cause 16+i-2
RESET_MTVEC, 32'h0000_0100, mtvec value after reset

Ports:
clk  in  1  clock
rst  in  1  synchronous active-low reset
valid_in  in  1  memory stage presents an instruction
stall_out  out  1  upstream must hold its instruction this cycle
irq_in  in  NUM_IRQ  level-sensitive interrupt requests
instruction_in  in  wb_instr_t  decoded retire info (package)
rd_data_in  in  XLEN  result from execute/memory
source_data_in  in  XLEN  rs1 value (CSR write operand)
program_counter_in  in  XLEN  PC of the instruction
next_program_counter_in  in  XLEN  sequential/branch successor PC
jump_valid_out  out  1  redirect fetch
jump_address_out  out  XLEN  redirect target
flush_out  out  1  squash all younger in-flight instructions
forwarding_out  out  fwd_t  {valid, rd_addr, data} register write/forward

Behaviour:
- Reset (rst==0 at posedge): state RUN; all outputs 0; MIE=MPIE=0; mie=0; mepc=0; mcause=0; mtvec=RESET_MTVEC. Reset mid-trap aborts the trap: no CSR update and no jump.
- mip[i]=irq_in[i], unregistered. Interrupt pending = MIE & |(irq_in & mie).
- Decision in RUN with valid_in=1, highest priority first:
  1. Pending interrupt, lowest index wins: instruction not retired; mepc<=PC; mcause<={1,cause}.
  2. Exception, illegal > ebreak > ecall, causes 2/3/11: no retire, no rd write; mepc<=PC; mcause<={0,cause}.
  3. mret: jump to mepc; MIE<=MPIE; MPIE<=1. No rd write.
  4. Normal retire: if rd_write and rd_addr!=0, forwarding_out<={1,rd_addr,value} one cycle after acceptance (registered). value=rd_data_in, or the old CSR value for a CSR op.
- Taking a trap (cases 1 and 2):
  - Same edge: MPIE<=MIE, MIE<=0; FSM moves to TRAP.
  - In TRAP (exactly one cycle): jump_valid_out=1, jump_address_out=mtvec, with bits[1:0] forced to 0; flush_out=1; stall_out=1.
  - Next cycle: back to RUN.
- mret redirect: jump_valid_out/flush_out pulse in the cycle after acceptance; no TRAP state is used.
- valid_in=0 in RUN: nothing happens, even if an interrupt is pending. Interrupts are only taken at an instruction boundary.
- CSR ops: csr_op 0=none, 1=write, 2=set, 3=clear; operand is source_data_in.
  - Writable CSRs: mstatus bits 3/7, mie[NUM_IRQ-1:0] mapped to the cause bit positions, mtvec, mepc (bits[1:0]=0), mcause.
  - mip is read-only.
  - Unknown csr_addr raises illegal (cause 2).
  - A CSR write that sets MIE takes effect for the next instruction, never the current one.
- Stall/flush: stall_out=1 only in TRAP. An instruction presented in TRAP is ignored, because flush kills it upstream.
- Forwarding bus is a single-cycle pulse. rd_addr=0 never produces valid=1.
- All arithmetic is XLEN-wide; PCs wrap modulo 2^XLEN; no overflow handling.

Decomposition:
- Package writeback_pkg:
  - wb_instr_t: rd_addr, rd_write, csr_op[1:0], csr_addr[11:0], is_ecall, is_ebreak, is_illegal, is_mret
  - fwd_t
  - CSR address constants: 0x300, 0x304, 0x305, 0x341, 0x342, 0x344
  - cause constants
  - state enum {RUN, TRAP}
- One sub-module, trap_csr_file: CSR storage, read mux, set/clear logic, interrupt priority encoder. The top level holds the FSM and retire register.

Test Plan:
- Retire with rd_addr=5, rd_write=1, rd_data_in=32'hDEAD_BEEF -> next cycle forwarding_out={1,5,DEADBEEF}; rd_addr=0 -> valid stays 0.
- Write mtvec=0x200 and mie bit 7; set MIE; assert irq_in[1] while PC=0x40 is valid -> no retire; mepc=0x40, mcause=0x8000_0007, MIE=0, MPIE=1; next cycle jump_valid/flush/stall=1 with address 0x200.
- irq_in=2'b11 with both enabled -> mcause=0x8000_000B (external wins). Same with MIE=0 -> normal retire.
- Illegal instruction plus ecall flag at PC=0x80 -> mcause=2, mepc=0x80, no forwarding. Then mret -> jump to 0x80, MIE restored from MPIE.
- CSR read of mcause into rd=3 while writing 0 -> forwarding_out data = old mcause; a subsequent read returns 0.
- rst=0 asserted during the TRAP cycle -> all outputs 0 next cycle, mtvec=RESET_MTVEC, no jump issued.
